// File: rtl/ser2par_detect.sv
// Serial-to-parallel frame receiver with a Mealy 1-0-1-1 detector.
// Define SER2PAR_DETECT_OVERLAP_EN for overlapping pattern detection.
module ser2par_detect #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic              din,
  output logic [DATA_W-1:0] par_out,
  output logic              frame_valid,
  output logic              detect,
  output logic [3:0]        match_cnt,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } st_t;

  typedef enum logic [1:0] {
    D0,
    D1,
    D2,
    D3
  } dt_t;

`ifdef SER2PAR_DETECT_OVERLAP_EN
  localparam dt_t DHIT = D1;
`else
  localparam dt_t DHIT = D0;
`endif

  st_t              st;
  dt_t              dst;
  dt_t              dnxt;
  logic [CW-1:0]    cnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] word;
  logic             armed;
  logic             samp;
  logic             last;

  always_comb begin
    samp      = (st == SHIFT) && set;
    detect    = samp && (dst == D3) && din;
    last      = (cnt == CW'(DATA_W - 1));
    word      = sreg;
    word[cnt] = din;
  end

  always_comb begin
    dnxt = D0;
    unique case (dst)
      D0: dnxt = din ? D1 : D0;
      D1: dnxt = din ? D1 : D2;
      D2: dnxt = din ? D3 : D0;
      D3: dnxt = din ? DHIT : D2;
      default: dnxt = D0;
    endcase
  end

  // armed stays low after reset until set is seen low, so a
  // set held through reset cannot start a frame mid-stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      dst         <= D0;
      cnt         <= '0;
      sreg        <= '0;
      par_out     <= '0;
      frame_valid <= 1'b0;
      match_cnt   <= '0;
      busy        <= 1'b0;
      armed       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (!set) begin
        st    <= IDLE;
        busy  <= 1'b0;
        dst   <= D0;
        armed <= 1'b1;
      end else begin
        unique case (st)
          IDLE: begin
            if (armed) begin
              st        <= SHIFT;
              busy      <= 1'b1;
              cnt       <= '0;
              sreg      <= '0;
              match_cnt <= '0;
              dst       <= D0;
            end
          end
          SHIFT: begin
            sreg <= word;
            cnt  <= cnt + 1'b1;
            dst  <= dnxt;
            if (detect && (match_cnt != 4'hF))
              match_cnt <= match_cnt + 4'd1;
            if (last) begin
              par_out     <= word;
              frame_valid <= 1'b1;
              st          <= DONE;
              busy        <= 1'b0;
            end
          end
          DONE: st <= DONE;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ser2par_detect.sv
// Bench for ser2par_detect: frame-level model plus directed frames.
// Pattern counting follows SER2PAR_DETECT_OVERLAP_EN like the design.
module tb_ser2par_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set;
  logic       din;
  logic [7:0] par_out;
  logic       frame_valid;
  logic       detect;
  logic [3:0] match_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int fv_seen  = 0;
  int det_seen = 0;
  int det_pos  = -1;

  ser2par_detect #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set         (set),
    .din         (din),
    .par_out     (par_out),
    .frame_valid (frame_valid),
    .detect      (detect),
    .match_cnt   (match_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Occurrences of 1011 among the first n arrived bits.
  function automatic int count_hits(input logic [15:0] b, input int n);
    int c  = 0;
    int le = -1;
    for (int i = 3; i < n; i++) begin
      if (b[i-3] && !b[i-2] && b[i-1] && b[i]) begin
`ifdef SER2PAR_DETECT_OVERLAP_EN
        c++;
`else
        if (i - 3 > le) begin
          c++;
          le = i;
        end
`endif
      end
    end
    return (c > 15) ? 15 : c;
  endfunction

  // Frame model: 0 idle, 1 collecting bits, 2 frame complete.
  int          m_phase;
  bit          m_armed;
  int          m_n;
  logic [15:0] m_bits;
  logic [7:0]  m_par;
  logic        m_fv;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_armed = 0;
      m_n     = 0;
      m_bits  = '0;
      m_par   = '0;
      m_fv    = 0;
      m_cnt   = 0;
    end else begin
      m_fv = 0;
      if (!set) begin
        m_phase = 0;
        m_armed = 1;
      end else if (m_phase == 0) begin
        if (m_armed) begin
          m_phase = 1;
          m_n     = 0;
          m_bits  = '0;
          m_cnt   = 0;
        end
      end else if (m_phase == 1) begin
        m_bits[m_n] = din;
        m_n++;
        m_cnt = count_hits(m_bits, m_n);
        if (m_n == 8) begin
          m_par   = m_bits[7:0];
          m_fv    = 1;
          m_phase = 2;
        end
      end
    end
  end

  function automatic logic exp_detect();
    logic [15:0] nb;
    if (!(m_phase == 1 && set && din)) return 1'b0;
    nb = m_bits;
    nb[m_n] = 1'b1;
    return count_hits(nb, m_n + 1) > count_hits(m_bits, m_n);
  endfunction

  always @(negedge clk) begin
    chk("par_out", 32'(par_out), 32'(m_par));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("detect", 32'(detect), 32'(exp_detect()));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    if (frame_valid) fv_seen++;
    if (detect) begin
      det_seen++;
      det_pos = m_n;
    end
  end

  task automatic clr();
    fv_seen  = 0;
    det_seen = 0;
    det_pos  = -1;
  endtask

  // n edges with set high starting at E0, then one low cycle.
  task automatic frame(input logic [7:0] d, input int n);
    set = 1'b1;
    for (int k = 0; k < n; k++) begin
      din = (k >= 1 && k <= 8) ? d[k-1] : 1'b0;
      @(posedge clk);
      #1;
    end
    set = 1'b0;
    din = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set   = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    clr();
    frame(8'hAD, 10);
    chk("basic_par", 32'(par_out), 32'h0000_00AD);
    chk("basic_cnt", 32'(match_cnt), 32'd1);
    chk("basic_fv", 32'(fv_seen), 32'd1);
    chk("basic_det", 32'(det_seen), 32'd1);
    chk("basic_detpos", 32'(det_pos), 32'd3);

    clr();
    set = 1'b1;
    din = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_par", 32'(par_out), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_det", 32'(detect), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_nostart_fv", 32'(fv_seen), 32'd0);
    chk("rst_nostart_busy", 32'(busy), 32'd0);
    set = 1'b0;
    din = 1'b0;
    @(posedge clk);
    #1;

    clr();
    frame(8'h6D, 9);
    chk("ovl_par", 32'(par_out), 32'h0000_006D);
`ifdef SER2PAR_DETECT_OVERLAP_EN
    chk("ovl_cnt", 32'(match_cnt), 32'd2);
`else
    chk("ovl_cnt", 32'(match_cnt), 32'd1);
`endif

    clr();
    frame(8'hFF, 6);
    chk("abort_fv", 32'(fv_seen), 32'd0);
    chk("abort_par", 32'(par_out), 32'h0000_006D);

    clr();
    frame(8'h0B, 9);
    chk("after_abort_par", 32'(par_out), 32'h0000_000B);
    chk("after_abort_fv", 32'(fv_seen), 32'd1);

    clr();
    frame(8'h00, 9);
    chk("b2b0_par", 32'(par_out), 32'd0);
    chk("b2b0_cnt", 32'(match_cnt), 32'd0);
    frame(8'hDB, 9);
    chk("b2b1_par", 32'(par_out), 32'h0000_00DB);
    chk("b2b_fv", 32'(fv_seen), 32'd2);
`ifdef SER2PAR_DETECT_OVERLAP_EN
    chk("b2b1_cnt", 32'(match_cnt), 32'd2);
`else
    chk("b2b1_cnt", 32'(match_cnt), 32'd1);
`endif

    clr();
    frame(8'h0D, 29);
    chk("trail_par", 32'(par_out), 32'h0000_000D);
    chk("trail_cnt", 32'(match_cnt), 32'd1);
    chk("trail_det", 32'(det_seen), 32'd1);
    chk("trail_fv", 32'(fv_seen), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
